// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int unsigned RegIdxW         = 4;
  localparam int unsigned DefaultBaseAddr = 1024;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: combinational read, synchronous write, range-checked byte address.
module mem_stage_data_memory #(
  parameter int unsigned N        = 32,
  parameter int unsigned Depth    = 64,
  parameter int unsigned BaseAddr = 1024
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [N-1:0] addr_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] rdata_o,
  output logic         in_range_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [N-1:0]    mem_q [Depth];
  logic [N-1:0]    offset;
  logic [N-1:0]    word_idx;
  logic [IdxW-1:0] idx;

  // Wrap-around subtraction: addresses below the base become huge and fall out of range.
  always_comb begin
    offset     = addr_i - N'(BaseAddr);
    word_idx   = offset >> 2;
    in_range_o = (word_idx < N'(Depth));
    idx        = word_idx[IdxW-1:0];
    rdata_o    = in_range_o ? mem_q[idx] : '0;
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i && in_range_o) begin
      mem_q[idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: wait-state FSM around the data memory, plus the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_ENIn,
  input  logic               MEM_R_ENIn,
  input  logic               MEM_W_ENIn,
  input  logic [N-1:0]       ALU_ResIn,
  input  logic [N-1:0]       Val_RmIn,
  input  logic [RegIdxW-1:0] WB_DestIn,
  output logic [N-1:0]       ALU_ResOut,
  output logic [N-1:0]       DataMemoryOut,
  output logic               MEM_R_ENOut,
  output logic               WB_ENOut,
  output logic [RegIdxW-1:0] WB_DestOut,
  output logic               ready
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req;
  logic              mem_we;
  logic [N-1:0]      mem_rdata;
  logic              mem_in_range;

  logic [N-1:0]       alu_res_q, alu_res_d;
  logic [N-1:0]       dmem_q, dmem_d;
  logic               mem_r_en_q, mem_r_en_d;
  logic               wb_en_q, wb_en_d;
  logic [RegIdxW-1:0] wb_dest_q, wb_dest_d;

  assign req = MEM_R_ENIn | MEM_W_ENIn;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (req && (WAIT_CYCLES != 0)) begin
          ready   = 1'b0;
          state_d = StBusy;
          cnt_d   = CntW'(WAIT_CYCLES - 1);
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          ready   = 1'b1;
          state_d = StIdle;
        end else begin
          ready = 1'b0;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Store commits only on the completing edge; reset gating matters for zero-wait builds.
  assign mem_we = MEM_W_ENIn & ready & rst;

  mem_stage_data_memory #(
    .N        (N),
    .Depth    (DEPTH),
    .BaseAddr (BASE_ADDR)
  ) u_data_memory (
    .clk_i      (clk),
    .we_i       (mem_we),
    .addr_i     (ALU_ResIn),
    .wdata_i    (Val_RmIn),
    .rdata_o    (mem_rdata),
    .in_range_o (mem_in_range)
  );

  // Stall edges load a bubble so write-back never sees an instruction twice.
  always_comb begin
    alu_res_d  = '0;
    dmem_d     = '0;
    mem_r_en_d = 1'b0;
    wb_en_d    = 1'b0;
    wb_dest_d  = '0;
    if (ready) begin
      alu_res_d  = ALU_ResIn;
      dmem_d     = (MEM_R_ENIn && !MEM_W_ENIn && mem_in_range) ? mem_rdata : '0;
      mem_r_en_d = MEM_R_ENIn;
      wb_en_d    = WB_ENIn;
      wb_dest_d  = WB_DestIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      alu_res_q  <= '0;
      dmem_q     <= '0;
      mem_r_en_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_res_q  <= alu_res_d;
      dmem_q     <= dmem_d;
      mem_r_en_q <= mem_r_en_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  assign ALU_ResOut    = alu_res_q;
  assign DataMemoryOut = dmem_q;
  assign MEM_R_ENOut   = mem_r_en_q;
  assign WB_ENOut      = wb_en_q;
  assign WB_DestOut    = wb_dest_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage ARM pipeline. Sits between the EXE/MEM register and the write-back stage.
- Performs loads and stores against an internal word-addressed data memory. A parameterised wait-state counter models slow SRAM.
- Includes the MEM/WB pipeline register, whose outputs drive write-back directly.
- Raises a ready/stall handshake so the hazard/freeze logic can hold upstream stages during multi-cycle accesses.

Parameters:
- N, 32: datapath width.
- DEPTH, 64: data memory depth in words.
- BASE_ADDR, 1024: byte address mapped to word 0.
- WAIT_CYCLES, 2: extra cycles per memory access; 0 means single-cycle access.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- WB_ENIn  in  1  register write-back enable from EXE/MEM.
- MEM_R_ENIn  in  1  load request.
- MEM_W_ENIn  in  1  store request.
- ALU_ResIn  in  N  effective byte address or ALU result.
- Val_RmIn  in  N  store data.
- WB_DestIn  in  4  destination register index.
- ALU_ResOut  out  N  registered ALU result.
- DataMemoryOut  out  N  registered load data.
- MEM_R_ENOut  out  1  registered load flag; selects load data in write-back.
- WB_ENOut  out  1  registered write-back enable.
- WB_DestOut  out  4  registered destination.
- ready  out  1  1 = stage completes this cycle; 0 = upstream must freeze and hold inputs stable.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs = 0.
  - FSM = IDLE; counter = 0.
  - Memory contents are not cleared.
  - An in-flight store is dropped.
- req = MEM_R_ENIn | MEM_W_ENIn.
- Word index = (ALU_ResIn - BASE_ADDR) >> 2, using N-bit wrap-around subtraction.
  - In range only if the index is < DEPTH.
  - Out of range: store ignored, load returns 0.
  - Address bits [1:0] are ignored.
- Memory: combinational read, synchronous write. Write commits on the completing edge only.
- FSM states:
  - IDLE:
    - If req and WAIT_CYCLES>0: ready=0; next BUSY; cnt=WAIT_CYCLES-1.
    - Otherwise: ready=1; next IDLE.
  - BUSY:
    - If cnt==0: ready=1; next IDLE.
    - Otherwise: ready=0; cnt decrements.
- Latency:
  - Access presented in cycle T completes at the edge ending cycle T+WAIT_CYCLES, so an access occupies WAIT_CYCLES+1 cycles.
  - Non-memory instructions take 1 cycle.
- MEM/WB register:
  - On a rising edge with ready=1: loads ALU_ResIn, read data, MEM_R_ENIn, WB_ENIn, WB_DestIn.
  - On a rising edge with ready=0: loads a bubble (WB_ENOut=0, MEM_R_ENOut=0, other fields 0), so write-back never repeats an instruction.
- Simultaneous MEM_R_ENIn and MEM_W_ENIn:
  - The store is performed.
  - DataMemoryOut = 0; MEM_R_ENOut takes the MEM_R_ENIn value.
- Back-to-back accesses: each access returns to IDLE for its completing cycle; the next request restarts the count. There is no pipelining of accesses.
- Inputs changing while ready=0 are a protocol violation. The block samples the address and data only on the completing cycle.

Decomposition:
- Shared package holds:
  - Register-index width (4).
  - FSM state encoding: IDLE, BUSY.
  - BASE_ADDR default.
- One natural sub-module: data_memory. It is the word array with combinational read, synchronous write and range check.
- The FSM, counter and MEM/WB register stay in mem_stage.

Test Plan:
- Reset release, no request: ready=1 every cycle. Inputs WB_ENIn=1, WB_DestIn=5, ALU_ResIn=0x7 → next cycle WB_ENOut=1, WB_DestOut=5, ALU_ResOut=0x7, MEM_R_ENOut=0.
- Store then load, WAIT_CYCLES=2: store addr 1032, data 0xDEADBEEF. ready is 0,0,1 over three cycles and WB_ENOut=0 during the stall. A following load from 1032 gives DataMemoryOut=0xDEADBEEF, MEM_R_ENOut=1 after three cycles.
- Out of range: store to 1020 and to 1024+4*64 leaves memory unchanged. A load from 1020 returns 0.
- WAIT_CYCLES=0 build: alternating stores and loads, ready constantly 1. Loaded data appears registered one cycle after presentation.
- Reset mid-access: assert rst low in the second BUSY cycle of a store to 1028 with data 0x55. Outputs go 0 immediately and the FSM returns to IDLE. A later load from 1028 returns the prior contents, not 0x55.
- Read and write together at 1036 with data 0x1234: memory word 3 = 0x1234, DataMemoryOut=0, MEM_R_ENOut=1.
